// File: rtl/multdiv_seq_if.sv
// Start/operand/result bundle for multdiv_seq.
// The bench drives through master; the divider core sits on slave.
interface multdiv_seq_if;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY
    );
    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/multdiv_seq.sv
// Sequential signed 32x32 Booth multiplier / non-restoring divider with a 33-cycle latency.
// Define MULTDIV_EARLY_DIV0_EN to finish divide-by-zero in 2 cycles instead of 33.
module cla_32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);
    logic [31:0] w_g, w_p, w_c;
    logic [8:0]  w_gc;

    assign w_g     = i_a & i_b;
    assign w_p     = i_a ^ i_b;
    assign w_gc[0] = i_cin;

    // 4-bit lookahead groups chained through group generate/propagate
    for (genvar k = 0; k < 8; k++) begin : g_blk
        localparam int B = 4 * k;
        logic w_bg, w_bp;
        assign w_c[B]   = w_gc[k];
        assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[k]);
        assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B]) | (w_p[B+1] & w_p[B] & w_gc[k]);
        assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) | (w_p[B+2] & w_p[B+1] & w_g[B])
                        | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[k]);
        assign w_bg = w_g[B+3] | (w_p[B+3] & w_g[B+2]) | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                    | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
        assign w_bp = &w_p[B+3:B];
        assign w_gc[k+1] = w_bg | (w_bp & w_gc[k]);
    end

    assign o_sum  = w_p ^ w_c;
    assign o_cout = w_gc[8];
endmodule

module multdiv_seq (
    input  logic         clock,
    input  logic         reset,
    multdiv_seq_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [5:0]  r_cnt;
    logic [31:0] r_acc, r_q, r_m, r_result;
    logic        r_q1, r_pt, r_mult, r_neg, r_divz, r_dovf, r_exc, r_rdy;
    logic        w_start, w_last, w_skip, w_do_mult, w_do_div, w_fin;
    logic [31:0] w_add_a, w_add_b, w_sum, w_nega_in, w_nega, w_negb, w_amag, w_bmag;
    logic        w_add_cin, w_cout, w_nega_co, w_bzero, w_mul_sgn, w_div_top, w_dovf_in;

    assign w_start = bus.ctrl_MULT | bus.ctrl_DIV;
    assign w_last  = (r_cnt == 6'd31);
`ifdef MULTDIV_EARLY_DIV0_EN
    assign w_skip  = r_divz;
`else
    assign w_skip  = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_start) begin
            w_next = bus.ctrl_MULT ? S_MULT : S_DIV;
        end else begin
            case (r_state)
                S_IDLE:  w_next = S_IDLE;
                S_MULT:  if (w_last) w_next = S_DONE;
                S_DIV:   if (w_last || w_skip) w_next = S_DONE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_do_mult = 1'b0;
        w_do_div  = 1'b0;
        w_fin     = 1'b0;
        case (r_state)
            S_MULT:  w_do_mult = 1'b1;
            S_DIV:   w_do_div  = ~w_skip;
            S_DONE:  w_fin     = 1'b1;
            default: ;
        endcase
    end

    // Shared adder: Booth step, divide step, or final remainder correction
    always_comb begin
        w_add_a   = r_acc;
        w_add_b   = 32'd0;
        w_add_cin = 1'b0;
        if (w_do_mult) begin
            case ({r_q[0], r_q1})
                2'b01:   w_add_b = r_m;
                2'b10: begin
                    w_add_b   = ~r_m;
                    w_add_cin = 1'b1;
                end
                default: ;
            endcase
        end else if (w_do_div) begin
            w_add_a   = {r_acc[30:0], r_q[31]};
            w_add_b   = r_pt ? r_m : ~r_m;
            w_add_cin = ~r_pt;
        end else if (w_fin) begin
            w_add_b   = r_pt ? r_m : 32'd0;
        end
    end

    cla_32 u_main (.i_a(w_add_a), .i_b(w_add_b), .i_cin(w_add_cin), .o_sum(w_sum), .o_cout(w_cout));

    // 33rd bit of each sum, so a 0x80000000 operand cannot corrupt the sign
    assign w_mul_sgn = r_acc[31] ^ w_add_b[31] ^ w_cout;
    assign w_div_top = r_acc[31] ^ ~r_pt ^ w_cout;

    // Negators: operand magnitudes at start, quotient sign fix-up at the end
    assign w_nega_in = w_start ? ~bus.data_operandA : ~r_q;
    cla_32 u_nega (.i_a(w_nega_in), .i_b(32'd0), .i_cin(1'b1), .o_sum(w_nega), .o_cout(w_nega_co));
    cla_32 u_negb (.i_a(~bus.data_operandB), .i_b(32'd0), .i_cin(1'b1), .o_sum(w_negb), .o_cout(w_bzero));

    assign w_amag    = bus.data_operandA[31] ? w_nega : bus.data_operandA;
    assign w_bmag    = bus.data_operandB[31] ? w_negb : bus.data_operandB;
    assign w_dovf_in = (bus.data_operandA == 32'h8000_0000) && (bus.data_operandB == 32'hFFFF_FFFF);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= 6'd0;
            r_acc    <= 32'd0;
            r_q      <= 32'd0;
            r_m      <= 32'd0;
            r_q1     <= 1'b0;
            r_pt     <= 1'b0;
            r_mult   <= 1'b0;
            r_neg    <= 1'b0;
            r_divz   <= 1'b0;
            r_dovf   <= 1'b0;
            r_result <= 32'd0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (w_start) begin
                r_cnt  <= 6'd0;
                r_acc  <= 32'd0;
                r_q1   <= 1'b0;
                r_pt   <= 1'b0;
                r_mult <= bus.ctrl_MULT;
                r_q    <= bus.ctrl_MULT ? bus.data_operandB : w_amag;
                r_m    <= bus.ctrl_MULT ? bus.data_operandA : w_bmag;
                r_neg  <= bus.data_operandA[31] ^ bus.data_operandB[31];
                r_divz <= w_bzero;
                r_dovf <= w_dovf_in;
            end else if (w_do_mult) begin
                r_acc <= {w_mul_sgn, w_sum[31:1]};
                r_q   <= {w_sum[0], r_q[31:1]};
                r_q1  <= r_q[0];
                r_cnt <= r_cnt + 6'd1;
            end else if (w_do_div) begin
                r_acc <= w_sum;
                r_pt  <= w_div_top;
                r_q   <= {r_q[30:0], ~w_div_top};
                r_cnt <= r_cnt + 6'd1;
            end else if (w_fin) begin
                r_rdy <= 1'b1;
                if (r_mult) begin
                    r_result <= r_q;
                    r_exc    <= ~((&{r_acc, r_q[31]}) | ~(|{r_acc, r_q[31]}));
                end else begin
                    r_acc <= w_sum;
                    r_pt  <= 1'b0;
                    if (r_divz) begin
                        r_result <= 32'd0;
                        r_exc    <= 1'b1;
                    end else if (r_dovf) begin
                        r_result <= 32'h8000_0000;
                        r_exc    <= 1'b1;
                    end else begin
                        r_result <= (r_neg && !w_nega_co) ? w_nega : r_q;
                        r_exc    <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = r_rdy;
endmodule
